// File: rtl/pwm_peripheral.sv
// ---------------------------------------------------------------------------
// pwm_peripheral
//
// Purpose:
//   Drives 16 output pins from the SPI-written control registers.
//   Each pin is driven in one of three ways:
//     - forced low,
//     - held static high, or
//     - driven by one shared 8-bit PWM waveform.
//   A clock prescaler sets the PWM period.
//   The requested duty cycle is double-buffered into a shadow register.
//   The shadow is loaded only at a period boundary, so a duty change never
//   cuts a period short or stretches it.
//
// Parameters:
//   CLK_DIV          prescaler terminal count (1..65535).
//                    One PWM step lasts CLK_DIV clk cycles.
//                    One period lasts 256*CLK_DIV clk cycles.
//
// Ports:
//   clk              system clock; all logic runs on the rising edge
//   rst              synchronous, active-high reset
//   en_reg_out_7_0   output enable, pins 7..0
//   en_reg_out_15_8  output enable, pins 15..8
//   en_reg_pwm_7_0   PWM-mode select, pins 7..0
//   en_reg_pwm_15_8  PWM-mode select, pins 15..8
//   pwm_duty_cycle   requested duty, 0x00..0xFF
//   out              registered pin drive; bit i drives pin i
//   period_start     one-cycle pulse on the first cycle of each period
//                    that follows a wrap
// ---------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] TICK_AT = 16'(CLK_DIV - 1);

    logic [15:0] prescaler;
    logic [7:0]  pwm_cnt;
    logic [7:0]  duty_shadow;

    logic        tick;
    logic        wrap;
    logic        pwm_sig;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] pin_next;

    // Decode the step tick and the period wrap from the registered counters.
    //
    // Full duty (0xFF) is special-cased so that the pin stays high for the
    // whole period. Without it, the plain compare would leave one low step
    // at count 255.
    //
    // Pin mux, evaluated per bit:
    //   - the output enable wins over everything;
    //   - a pin that is enabled but not in PWM mode is static high.
    always_comb begin
        tick     = (prescaler == TICK_AT);
        wrap     = tick && (pwm_cnt == 8'hFF);
        pwm_sig  = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);
        en_out   = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pin_next = en_out & (~en_pwm | {16{pwm_sig}});
    end

    // All state lives in this one block.
    //
    // Reset puts every counter back at zero, so the first period after
    // reset starts cleanly at step 0 with duty 0x00.
    //
    // The shadow loads on the wrap edge. The new duty therefore takes effect
    // exactly when pwm_cnt returns to 0, which is the same cycle in which
    // period_start is high.
    //
    // The pins are registered and follow enable changes one cycle later,
    // with no alignment to the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= 16'd0;
            pwm_cnt      <= 8'd0;
            duty_shadow  <= 8'h00;
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            prescaler <= tick ? 16'd0 : prescaler + 16'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (wrap) begin
                duty_shadow <= pwm_duty_cycle;
            end
            out          <= pin_next;
            period_start <= wrap;
        end
    end

endmodule
